ram_dp_pipe: RTL

Parametrised simple-dual-port word RAM with one write port and one read port, sized for any power-of-two data width. The write port has byte enables. The read port uses a valid/ready request handshake and a configurable-latency response pipeline with backpressure, plus a selectable read-during-write mode and out-of-range error reporting. It serves as instruction/data backing store behind the core's memory interfaces.

---
 rtl/ram_dp_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ram_dp_pipe.sv
// Simple-dual-port word RAM: byte-masked write port, valid/ready read port
// with a stallable fixed-latency response pipeline and out-of-range reporting.
module ram_dp_pipe #(
   parameter int AddrBusWidth = 32,
   parameter int DataBusWidth = 32,
   parameter int MemSizeBytes = 1024,
   parameter int ReadLatency  = 1,
   parameter int RdwMode      = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_valid,
   input  logic [AddrBusWidth-1:0]   wr_addr,
   input  logic [DataBusWidth-1:0]   wr_data,
   input  logic [DataBusWidth/8-1:0] wr_sel,
   output logic                      wr_err,
   input  logic                      rd_req_valid,
   output logic                      rd_req_ready,
   input  logic [AddrBusWidth-1:0]   rd_addr,
   output logic                      rd_resp_valid,
   input  logic                      rd_resp_ready,
   output logic [DataBusWidth-1:0]   rd_resp_data,
   output logic                      rd_resp_err
);

   localparam int NumBytes = DataBusWidth / 8;
   localparam int OffLo    = $clog2(NumBytes);
   localparam int IdxHi    = $clog2(MemSizeBytes) - 1;
   localparam int IdxW     = IdxHi - OffLo + 1;
   localparam int Depth    = MemSizeBytes / NumBytes;
   localparam int Last     = ReadLatency - 1;
   localparam logic [AddrBusWidth:0] MemLimit = (AddrBusWidth + 1)'(MemSizeBytes);

   logic [DataBusWidth-1:0] r_mem [Depth];
   logic                    r_wr_err;
   logic                    r_vld [ReadLatency];
   logic                    r_err [ReadLatency];
   logic [DataBusWidth-1:0] r_dat [ReadLatency];

   logic                    w_wr_in_range;
   logic                    w_rd_in_range;
   logic                    w_wr_en;
   logic [IdxW-1:0]         w_wr_idx;
   logic [IdxW-1:0]         w_rd_idx;
   logic                    w_adv;
   logic                    w_accept;
   logic [DataBusWidth-1:0] w_rd_word;
   logic [DataBusWidth-1:0] w_rd_merged;
   logic [DataBusWidth-1:0] w_stage_in_data;

   assign w_wr_in_range = ({1'b0, wr_addr} < MemLimit);
   assign w_rd_in_range = ({1'b0, rd_addr} < MemLimit);
   assign w_wr_idx      = wr_addr[IdxHi:OffLo];
   assign w_rd_idx      = rd_addr[IdxHi:OffLo];
   assign w_wr_en       = rst && wr_valid && w_wr_in_range;

   // The pipeline only freezes when a valid response sits unconsumed at the output.
   assign w_adv        = !(r_vld[Last] && !rd_resp_ready);
   assign w_accept     = rd_req_valid && w_adv;
   assign rd_req_ready = w_adv;

   // Byte-masked array write; out-of-range and reset-cycle writes are dropped
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < NumBytes; b++) begin
            if (wr_sel[b]) begin
               r_mem[w_wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

   // One-cycle error pulse for a non-empty write outside the array
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_err <= 1'b0;
      end else begin
         r_wr_err <= wr_valid && !w_wr_in_range && (|wr_sel);
      end
   end

   // Array read with optional same-word write forwarding, zeroed when out of range
   always_comb begin
      w_rd_word   = r_mem[w_rd_idx];
      w_rd_merged = w_rd_word;
      if ((RdwMode != 0) && w_wr_en && (w_wr_idx == w_rd_idx)) begin
         for (int b = 0; b < NumBytes; b++) begin
            if (wr_sel[b]) begin
               w_rd_merged[b*8 +: 8] = wr_data[b*8 +: 8];
            end else begin
               w_rd_merged[b*8 +: 8] = w_rd_word[b*8 +: 8];
            end
         end
      end else begin
         w_rd_merged = w_rd_word;
      end
      if (w_rd_in_range) begin
         w_stage_in_data = w_rd_merged;
      end else begin
         w_stage_in_data = {DataBusWidth{1'b0}};
      end
   end

   // Response pipeline: all stages shift together; reset discards in-flight reads
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < ReadLatency; i++) begin
            r_vld[i] <= 1'b0;
            r_err[i] <= 1'b0;
            r_dat[i] <= {DataBusWidth{1'b0}};
         end
      end else if (w_adv) begin
         r_vld[0] <= w_accept;
         r_err[0] <= w_accept && !w_rd_in_range;
         r_dat[0] <= w_accept ? w_stage_in_data : {DataBusWidth{1'b0}};
         for (int i = 1; i < ReadLatency; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_err[i] <= r_err[i-1];
            r_dat[i] <= r_dat[i-1];
         end
      end
   end

   assign wr_err        = r_wr_err;
   assign rd_resp_valid = r_vld[Last];
   assign rd_resp_err   = r_err[Last];
   assign rd_resp_data  = r_dat[Last];

endmodule
